// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO unit: one shared shift/add-subtract datapath for MULT/MULTU/DIV/DIVU,
// plus the HI/LO registers written by results and by MTHI/MTLO.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_last;
  logic             w_idle_like;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [1:0]       r_op;
  logic [W-1:0]     r_opa;
  logic [W-1:0]     r_opb;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [2*W-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_signed;
  logic             w_is_div;
  logic [W-1:0]     w_abs_a;
  logic [W-1:0]     w_abs_b;
  logic [W:0]       w_madd;
  logic [2*W-1:0]   w_mstep;
  logic [W:0]       w_rsh;
  logic             w_borrow;
  logic [W-1:0]     w_rem_sub;
  logic [2*W-1:0]   w_dstep;
  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_res_hi;
  logic [W-1:0]     w_res_lo;

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;

  assign w_last      = (r_cnt == CW'(W - 1));
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PREP;
        end
      end
      S_PREP: w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PREP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_PREP) || (w_state_nxt == S_RUN) || (w_state_nxt == S_FIX);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign w_signed = ~r_op[0];
  assign w_is_div = r_op[1];
  assign w_abs_a  = (w_signed && r_a[W-1]) ? W'(-r_a) : r_a;
  assign w_abs_b  = (w_signed && r_b[W-1]) ? W'(-r_b) : r_b;

  // Multiply step: acc = {partial product, remaining multiplier bits}
  assign w_madd  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opa} : (W+1)'(0));
  assign w_mstep = {w_madd, r_acc[W-1:1]};

  // Restoring divide step: acc = {remainder, dividend bits shifting into quotient}
  assign w_rsh     = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_borrow  = (w_rsh < {1'b0, r_opb});
  assign w_rem_sub = W'(w_rsh[W-1:0] - r_opb);
  assign w_dstep   = {(w_borrow ? w_rsh[W-1:0] : w_rem_sub), r_acc[W-2:0], ~w_borrow};

  // Sign correction; divide-by-zero bypasses it and returns the raw dividend
  always_comb begin
    w_prod   = r_neg_q ? (2*W)'(-r_acc) : r_acc;
    w_res_hi = w_prod[2*W-1:W];
    w_res_lo = w_prod[W-1:0];
    if (w_is_div) begin
      if (r_opb == '0) begin
        w_res_hi = r_a;
        w_res_lo = '1;
      end else begin
        w_res_lo = r_neg_q ? W'(-r_acc[W-1:0])   : r_acc[W-1:0];
        w_res_hi = r_neg_r ? W'(-r_acc[2*W-1:W]) : r_acc[2*W-1:W];
      end
    end
  end

  // Datapath and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= a;
        r_b  <= b;
        r_op <= op;
      end
      if (w_idle_like) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
      case (r_state)
        S_PREP: begin
          r_opa   <= w_abs_a;
          r_opb   <= w_abs_b;
          r_neg_q <= w_signed & (r_a[W-1] ^ r_b[W-1]);
          r_neg_r <= w_signed & r_a[W-1];
          r_acc   <= w_is_div ? {W'(0), w_abs_a} : {W'(0), w_abs_b};
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_acc <= w_is_div ? w_dstep : w_mstep;
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random/directed bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_done_cyc = -1;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [63:0] mon_e;
  int          mon_l;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = sx * sy; return 64'(p); end
      2'd1: begin u = 64'(x) * 64'(y); return u; end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) return {32'(sx % sy), 32'(sx / sy)};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending result", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = lat_q.pop_front();
        check("result", {hi, lo}, mon_e);
        check("latency", 64'(cyc), 64'(mon_l));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Called just after a rising edge with the unit in IDLE or DONE
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    exp_q.push_back(model(o, x, y));
    lat_q.push_back(cyc + 1 + LAT);
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int nbusy);
    bit found;
    found = 1'b0;
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk); #1;
      if (done) begin found = 1'b1; break; end
      if (busy) nbusy++;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", LAT + 20);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
    int nb;
    start_op(o, x, y);
    wait_done(nb);
    check(name, {hi, lo}, exp);
    go_idle();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, d1, d2, saved;
    logic [31:0] x, y, keep;
    logic [1:0]  o;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    rst = 1'b0;
    go_idle();

    // Directed vectors
    start_op(2'd0, 32'hFFFF_FF61, 32'h58);
    wait_done(nb);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_C958);
    check("busy_span", 64'(nb), 64'(LAT));
    go_idle();
    run_vec("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_vec("mult_m1m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    run_vec("div_neg",   2'd2, 32'hFFFF_FFF6, 32'd3,        64'hFFFF_FFFF_FFFF_FFFD);
    run_vec("divu",      2'd3, 32'h3E4,       32'h29D,      64'h0000_0147_0000_0001);
    run_vec("divu_zero", 2'd3, 32'h6F,        32'd0,        64'h0000_006F_FFFF_FFFF);
    run_vec("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_vec("div_zero_neg", 2'd2, 32'h8000_0005, 32'd0,     64'h8000_0005_FFFF_FFFF);

    // start and MTHI in the middle of RUN are ignored
    start_op(2'd0, 32'hFFFF_FF61, 32'h58);
    repeat (6) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd3; a = 32'd77; b = 32'd5; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    wait_done(nb);
    check("ignored_mid_run", {hi, lo}, 64'hFFFF_FFFF_FFFF_C958);
    go_idle();
    saved = last_done_cyc;
    repeat (40) @(posedge clk);
    #1;
    check("no_second_run", 64'(last_done_cyc), 64'(saved));

    // MTLO in IDLE, then reset aborting a DIV
    keep = hi;
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo_idle", {hi, lo}, {keep, 32'hDEAD_BEEF});
    start_op(2'd2, 32'd1000, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    check("abort_regs", {hi, lo}, 64'd0);
    check("abort_flags", {62'd0, busy, done}, 64'd0);
    saved = last_done_cyc;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 64'(last_done_cyc), 64'(saved));

    // Back-to-back start in the DONE cycle
    start_op(2'd1, 32'd12345, 32'd678);
    wait_done(nb);
    d1 = cyc;
    start_op(2'd2, 32'hFFFF_FC00, 32'd9);
    wait_done(nb);
    d2 = cyc;
    check("b2b_gap", 64'(d2 - d1), 64'(LAT + 1));

    // MTHI in the DONE cycle wins over the committed result
    keep = lo;
    hi_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_done", {hi, lo}, {32'hCAFE_F00D, keep});

    // MTLO together with start lands first, then the result overwrites it
    lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
    start_op(2'd3, 32'd500, 32'd3);
    lo_we = 1'b0;
    check("mtlo_with_start", 64'(lo), 64'h0BAD_0BAD);
    wait_done(nb);
    go_idle();

    // Randomized traffic, occasionally back-to-back
    for (int n = 0; n < 30; n++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(0, 50)); y = 32'($urandom_range(1, 9)); end
        3: y = {{24{y[7]}}, y[7:0]};
        default: ;
      endcase
      start_op(o, x, y);
      wait_done(nb);
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
